// File: rtl/uart_receive_buffer_ctrl_pkg.sv
// Shared definitions for the UART receive buffer controller.
// Provides the entry layout {bi, fe, pe, data[7:0]}, the trigger-level
// constants with their select decode, and the timeout counter width.
package uart_rx_pkg;

    localparam int ENTRY_W = 11;
    localparam int BI_IDX  = 10;
    localparam int FE_IDX  = 9;
    localparam int PE_IDX  = 8;

    localparam logic [4:0] TRIG_LVL_1  = 5'd1;
    localparam logic [4:0] TRIG_LVL_4  = 5'd4;
    localparam logic [4:0] TRIG_LVL_8  = 5'd8;
    localparam logic [4:0] TRIG_LVL_14 = 5'd14;

    localparam int TMO_W = 10;

    function automatic logic [4:0] trig_level(input logic [1:0] sel);
        case (sel)
            2'b00:   trig_level = TRIG_LVL_1;
            2'b01:   trig_level = TRIG_LVL_4;
            2'b10:   trig_level = TRIG_LVL_8;
            default: trig_level = TRIG_LVL_14;
        endcase
    endfunction

endpackage

// File: rtl/uart_receive_buffer_ctrl_if.sv
// Bus between the receiver/host side and the receive buffer controller.
// slave  : the buffer controller (consumes receiver status and host strobes,
//          drives read data and status flags).
// master : the receiver top / register file driving it.
interface uart_receive_buffer_ctrl_if;
    logic [7:0] rsr_data;
    logic       parity_error;
    logic       frame_error;
    logic       uart_break;
    logic       receive_load_en;
    logic       sample_edge;
    logic       fifo_en;
    logic       rx_fifo_rst;
    logic [1:0] rx_trig;
    logic       rbr_rd;
    logic       lsr_rd;
    logic [7:0] rbr_data;
    logic       dr;
    logic       oe;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       rx_fifo_err;
    logic       rx_trig_int;
    logic       rx_timeout_int;
    logic [4:0] rx_count;

    modport slave (
        input  rsr_data, parity_error, frame_error, uart_break, receive_load_en,
               sample_edge, fifo_en, rx_fifo_rst, rx_trig, rbr_rd, lsr_rd,
        output rbr_data, dr, oe, pe, fe, bi, rx_fifo_err, rx_trig_int,
               rx_timeout_int, rx_count
    );

    modport master (
        output rsr_data, parity_error, frame_error, uart_break, receive_load_en,
               sample_edge, fifo_en, rx_fifo_rst, rx_trig, rbr_rd, lsr_rd,
        input  rbr_data, dr, oe, pe, fe, bi, rx_fifo_err, rx_trig_int,
               rx_timeout_int, rx_count
    );
endinterface

// File: rtl/uart_receive_buffer_ctrl_fifo.sv
// 16-entry circular receive store.
// Ports: pclk/presetn clock and async active-low reset; clr empties the
// store; push writes wdata at the tail; pop advances the head; overwrite
// replaces the head entry in place (single-entry overrun); head is the
// entry at the read pointer; count is the number of entries held (0..16).
module uart_rx_fifo
    import uart_rx_pkg::*;
(
    input  logic               pclk,
    input  logic               presetn,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  logic               overwrite,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] head,
    output logic [4:0]         count
);

    logic [ENTRY_W-1:0] mem [16];
    logic [3:0]         wptr;
    logic [3:0]         rptr;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 4'd1;
            end else if (overwrite) begin
                mem[rptr] <= wdata;
            end
            if (pop) rptr <= rptr + 4'd1;
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/uart_receive_buffer_ctrl.sv
// UART receive buffer controller.
// Captures received characters with their status into a 16-entry FIFO (or
// a single holding entry when the FIFO is disabled), serves host reads and
// produces data-ready, overrun, error, trigger and character-timeout flags.
// Ports: pclk clock; presetn async active-low reset; bus (slave modport)
// carries receiver inputs, host strobes and all status outputs.
module uart_receive_buffer_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_TICKS = 640
) (
    input logic                       pclk,
    input logic                       presetn,
    uart_receive_buffer_ctrl_if.slave bus
);

    localparam logic [4:0]       DEPTH_CNT = 5'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT_TICKS);

    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] wdata;
    logic [4:0]         count;
    logic [4:0]         err_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               fifo_en_q;
    logic               oe_q;
    logic               clr, empty, at_cap;
    logic               push, pop, overwrite, overrun;
    logic               new_err, head_err;

    assign wdata    = {bus.uart_break, bus.frame_error, bus.parity_error, bus.rsr_data};
    assign new_err  = bus.uart_break | bus.frame_error | bus.parity_error;
    assign head_err = |head[BI_IDX:PE_IDX];

    // Toggling FIFO mode empties the store just like an explicit reset pulse.
    assign clr    = bus.rx_fifo_rst | (bus.fifo_en != fifo_en_q);
    assign empty  = (count == 5'd0);
    assign at_cap = bus.fifo_en ? (count == DEPTH_CNT) : (count == 5'd1);

    // A pop in the same cycle frees a slot, so a full store still accepts.
    assign pop       = bus.rbr_rd & ~empty & ~clr;
    assign push      = bus.receive_load_en & ~clr & (~at_cap | pop);
    assign overrun   = bus.receive_load_en & ~clr & at_cap & ~pop;
    assign overwrite = overrun & ~bus.fifo_en;

    uart_rx_fifo u_fifo (
        .pclk      (pclk),
        .presetn   (presetn),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .overwrite (overwrite),
        .wdata     (wdata),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            fifo_en_q <= 1'b0;
            oe_q      <= 1'b0;
            err_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            fifo_en_q <= bus.fifo_en;

            if (overrun)         oe_q <= 1'b1;
            else if (bus.lsr_rd) oe_q <= 1'b0;

            // An in-place overwrite both removes the old head and adds the new one.
            if (clr)
                err_cnt <= '0;
            else
                err_cnt <= err_cnt
                           + {4'd0, (push | overwrite) & new_err}
                           - {4'd0, (pop | overwrite) & head_err};

            if (clr || push || pop || overwrite || empty || !bus.fifo_en)
                tmo_cnt <= '0;
            else if (bus.sample_edge && tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.dr             = ~empty;
    assign bus.rbr_data       = empty ? 8'h00 : head[7:0];
    assign bus.pe             = ~empty & head[PE_IDX];
    assign bus.fe             = ~empty & head[FE_IDX];
    assign bus.bi             = ~empty & head[BI_IDX];
    assign bus.oe             = oe_q;
    assign bus.rx_fifo_err    = (err_cnt != 5'd0);
    assign bus.rx_trig_int    = bus.fifo_en ? (count >= trig_level(bus.rx_trig)) : ~empty;
    assign bus.rx_timeout_int = (tmo_cnt == TMO_MAX);
    assign bus.rx_count       = count;

endmodule
